// File: rtl/avalon_mm_host.sv
// avalon_mm_host: turns a valid/ready command stream into Avalon-MM
// transfers with pipelined reads, a bounded outstanding count and a read timeout.
module avalon_mm_host #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 8,
    parameter int BE_W        = 4,
    parameter int MAX_PENDING = 4,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_address,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [BE_W-1:0]   cmd_byteenable,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        pending_count,
    output logic              timeout_err,
    input  logic              err_clear,
    output logic              chipselect,
    output logic              read_n,
    output logic              write_n,
    output logic              beginTransfer,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] writeData,
    output logic [BE_W-1:0]   byteEnable_n,
    input  logic [DATA_W-1:0] readData,
    input  logic              readdatavalid,
    input  logic              waitrequest
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t state;
    state_t state_nx;

    logic              chipselect_nx;
    logic              read_n_nx;
    logic              write_n_nx;
    logic              begin_nx;
    logic [ADDR_W-1:0] address_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic [BE_W-1:0]   be_n_nx;

    logic          slot_free;
    logic          rd_on_bus;
    logic          rd_done;
    logic          rdv_take;
    logic          read_ok;
    logic          accept;
    logic [4:0]    rd_load;
    logic [TW-1:0] tmo_cnt;

    // A read on the bus that completes this cycle already occupies a slot.
    assign rd_on_bus = (state == XFER) && !read_n;
    assign rd_done   = rd_on_bus && !waitrequest;
    assign rdv_take  = readdatavalid && (pending_count != 4'd0);
    assign rd_load   = {1'b0, pending_count} + {4'd0, rd_on_bus};
    assign read_ok   = rd_load < 5'(MAX_PENDING);
    assign slot_free = (state == IDLE) || !waitrequest;
    assign cmd_ready = !reset && slot_free && (cmd_write || read_ok);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_nx      = state;
        chipselect_nx = chipselect;
        read_n_nx     = read_n;
        write_n_nx    = write_n;
        begin_nx      = 1'b0;
        address_nx    = address;
        wdata_nx      = writeData;
        be_n_nx       = byteEnable_n;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (!waitrequest && !accept) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (accept) begin
            chipselect_nx = 1'b1;
            read_n_nx     = cmd_write;
            write_n_nx    = !cmd_write;
            begin_nx      = 1'b1;
            address_nx    = cmd_address;
            wdata_nx      = cmd_wdata;
            be_n_nx       = ~cmd_byteenable;
        end else if ((state == XFER) && !waitrequest) begin
            chipselect_nx = 1'b0;
            read_n_nx     = 1'b1;
            write_n_nx    = 1'b1;
            be_n_nx       = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            chipselect    <= 1'b0;
            read_n        <= 1'b1;
            write_n       <= 1'b1;
            beginTransfer <= 1'b0;
            address       <= '0;
            writeData     <= '0;
            byteEnable_n  <= '1;
        end else begin
            state         <= state_nx;
            chipselect    <= chipselect_nx;
            read_n        <= read_n_nx;
            write_n       <= write_n_nx;
            beginTransfer <= begin_nx;
            address       <= address_nx;
            writeData     <= wdata_nx;
            byteEnable_n  <= be_n_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_count <= 4'd0;
        end else if (rd_done && !rdv_take) begin
            pending_count <= pending_count + 4'd1;
        end else if (!rd_done && rdv_take) begin
            pending_count <= pending_count - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rdv_take;
            if (rdv_take) begin
                rsp_data <= readData;
            end
        end
    end

    // Counter saturates at TIMEOUT; the flag stays set until err_clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if (err_clear) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else if ((pending_count == 4'd0) || rdv_take) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TW'(TIMEOUT)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_host.sv
// tb_avalon_mm_host: directed commands, a responder model that answers
// reads a fixed number of cycles later, and a response scoreboard.
`timescale 1ns/1ps
module tb_avalon_mm_host;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 8;
    localparam int BE_W        = 4;
    localparam int MAX_PENDING = 4;
    localparam int TIMEOUT     = 16;
    // readdatavalid comes 3 cycles after pending_count has counted the read
    localparam int RSP_LAT     = 4;

    logic              clk;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_wdata;
    logic [BE_W-1:0]   cmd_byteenable;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        pending_count;
    logic              timeout_err;
    logic              err_clear;
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic              beginTransfer;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writeData;
    logic [BE_W-1:0]   byteEnable_n;
    logic [DATA_W-1:0] readData;
    logic              readdatavalid;
    logic              waitrequest;

    avalon_mm_host #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .BE_W(BE_W),
        .MAX_PENDING(MAX_PENDING),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_address(cmd_address),
        .cmd_wdata(cmd_wdata),
        .cmd_byteenable(cmd_byteenable),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .pending_count(pending_count),
        .timeout_err(timeout_err),
        .err_clear(err_clear),
        .chipselect(chipselect),
        .read_n(read_n),
        .write_n(write_n),
        .beginTransfer(beginTransfer),
        .address(address),
        .writeData(writeData),
        .byteEnable_n(byteEnable_n),
        .readData(readData),
        .readdatavalid(readdatavalid),
        .waitrequest(waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         due_q[$];
    logic [7:0] dat_q[$];
    bit         rsp_en = 1'b1;
    int         inj_req = 0;
    int         inj_seen = 0;
    logic       rdv_prev = 1'b0;

    logic [7:0] exp_tbl [6] = '{8'h1A, 8'h1B, 8'h18, 8'h19, 8'h1E, 8'h1F};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Responder: data = address[7:0] ^ 8'h5A, returned RSP_LAT cycles later.
    task automatic responder();
        forever begin
            @(posedge clk);
            rdv_prev = readdatavalid;
            if (reset) begin
                due_q.delete();
                dat_q.delete();
            end else if (rsp_en && chipselect && !read_n && !waitrequest) begin
                due_q.push_back(cyc + RSP_LAT);
                dat_q.push_back(address[7:0] ^ 8'h5A);
            end
            cyc++;
            #1;
            readdatavalid = 1'b0;
            readData      = 8'h00;
            if (inj_seen != inj_req) begin
                inj_seen      = inj_req;
                readdatavalid = 1'b1;
                readData      = 8'hEE;
            end else if (due_q.size() > 0 && due_q[0] == cyc) begin
                readdatavalid = 1'b1;
                readData      = dat_q.pop_front();
                void'(due_q.pop_front());
            end
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
            end else if (rsp_valid) begin
                chk("rsp_after_rdv", 32'(rdv_prev), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    chk("rsp_data", 32'(rsp_data), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cs"}, 32'(chipselect), 32'd0);
        chk({tag, "_read_n"}, 32'(read_n), 32'd1);
        chk({tag, "_write_n"}, 32'(write_n), 32'd1);
        chk({tag, "_begin"}, 32'(beginTransfer), 32'd0);
        chk({tag, "_addr"}, address, 32'd0);
        chk({tag, "_wdata"}, 32'(writeData), 32'd0);
        chk({tag, "_be_n"}, 32'(byteEnable_n), 32'hF);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_pending"}, 32'(pending_count), 32'd0);
        chk({tag, "_tmo"}, 32'(timeout_err), 32'd0);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        while ((pending_count != 0 || chipselect || rsp_valid ||
                readdatavalid) && n < 200) begin
            step();
            smp();
            n++;
        end
        chk({tag, "_drain"}, 32'(pending_count), 32'd0);
    endtask

    task automatic t_write();
        step();
        cmd_valid      = 1'b1;
        cmd_write      = 1'b1;
        cmd_address    = 32'h10;
        cmd_wdata      = 8'hA5;
        cmd_byteenable = 4'h1;
        waitrequest    = 1'b0;
        smp();
        chk("t1_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        smp();
        chk("t1_cs", 32'(chipselect), 32'd1);
        chk("t1_write_n", 32'(write_n), 32'd0);
        chk("t1_read_n", 32'(read_n), 32'd1);
        chk("t1_begin", 32'(beginTransfer), 32'd1);
        chk("t1_addr", address, 32'h10);
        chk("t1_wdata", 32'(writeData), 32'hA5);
        chk("t1_be_n", 32'(byteEnable_n), 32'hE);
        step();
        smp();
        chk("t1_idle_cs", 32'(chipselect), 32'd0);
        chk("t1_idle_write_n", 32'(write_n), 32'd1);
        chk("t1_idle_be_n", 32'(byteEnable_n), 32'hF);
        chk("t1_idle_begin", 32'(beginTransfer), 32'd0);
        chk("t1_pending", 32'(pending_count), 32'd0);
    endtask

    task automatic t_stall();
        step();
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 32'h20;
        waitrequest = 1'b1;
        exp_q.push_back(8'h7A);
        smp();
        chk("t2_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) waitrequest = 1'b0;
            smp();
            chk("t2_read_n", 32'(read_n), 32'd0);
            chk("t2_addr", address, 32'h20);
            chk("t2_begin", 32'(beginTransfer), 32'(i == 0));
            if (i < 3) chk("t2_ready_stall", 32'(cmd_ready), 32'd0);
            step();
        end
        smp();
        chk("t2_pending", 32'(pending_count), 32'd1);
        chk("t2_cs_off", 32'(chipselect), 32'd0);
        wait_quiet("t2");
    endtask

    task automatic t_pipe();
        int acc_cyc[6];
        int first_rdv = -1;
        int peak = 0;
        int i = 0;
        int n = 0;
        step();
        while ((i < 6 || pending_count != 0 || chipselect) && n < 100) begin
            if (i < 6) begin
                cmd_valid   = 1'b1;
                cmd_write   = 1'b0;
                cmd_address = 32'h40 + 32'(i);
            end else begin
                cmd_valid = 1'b0;
            end
            smp();
            if (int'(pending_count) > peak) peak = int'(pending_count);
            if (readdatavalid && first_rdv < 0) first_rdv = cyc;
            if (cmd_valid && cmd_ready) begin
                acc_cyc[i] = cyc;
                exp_q.push_back(exp_tbl[i]);
                i++;
            end
            step();
            n++;
        end
        cmd_valid = 1'b0;
        chk("t3_accepted", 32'(i), 32'd6);
        chk("t3_peak", 32'(peak), 32'd4);
        chk("t3_b2b", 32'(acc_cyc[1] - acc_cyc[0]), 32'd1);
        chk("t3_blocked", 32'(acc_cyc[4] - acc_cyc[3]), 32'd3);
        chk("t3_after_rdv", 32'(acc_cyc[4] - first_rdv), 32'd1);
        smp();
        wait_quiet("t3");
    endtask

    task automatic t_incdec();
        step();
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 32'h50;
        exp_q.push_back(8'h0A);
        smp();
        chk("t4_ready_a", 32'(cmd_ready), 32'd1);
        step();
        cmd_address = 32'h51;
        exp_q.push_back(8'h0B);
        smp();
        chk("t4_ready_b", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        smp();
        step();
        smp();
        chk("t4_pending_pre", 32'(pending_count), 32'd2);
        step();
        cmd_valid   = 1'b1;
        cmd_address = 32'h52;
        exp_q.push_back(8'h08);
        smp();
        chk("t4_ready_c", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        smp();
        chk("t4_pending_same", 32'(pending_count), 32'd2);
        chk("t4_rdv", 32'(readdatavalid), 32'd1);
        chk("t4_rd_bus", 32'(read_n), 32'd0);
        step();
        smp();
        chk("t4_pending_after", 32'(pending_count), 32'd2);
        chk("t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t4_rsp_data", 32'(rsp_data), 32'h0A);
        wait_quiet("t4");
    endtask

    task automatic t_timeout();
        int n = 0;
        bit ok = 1'b1;
        rsp_en = 1'b0;
        step();
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 32'h60;
        smp();
        chk("t5_ready", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        smp();
        while (pending_count == 0 && n < 20) begin
            step();
            smp();
            n++;
        end
        chk("t5_pending", 32'(pending_count), 32'd1);
        if (timeout_err) ok = 1'b0;
        for (int j = 1; j < 16; j++) begin
            step();
            smp();
            if (timeout_err) ok = 1'b0;
        end
        chk("t5_quiet", 32'(ok), 32'd1);
        step();
        smp();
        chk("t5_set", 32'(timeout_err), 32'd1);
        chk("t5_not_blocking", 32'(cmd_ready), 32'd1);
        step();
        err_clear = 1'b1;
        smp();
        chk("t5_still_set", 32'(timeout_err), 32'd1);
        step();
        err_clear = 1'b0;
        smp();
        chk("t5_cleared", 32'(timeout_err), 32'd0);
        ok = 1'b1;
        for (int j = 1; j < 16; j++) begin
            step();
            smp();
            if (timeout_err) ok = 1'b0;
        end
        chk("t5_quiet2", 32'(ok), 32'd1);
        step();
        smp();
        chk("t5_reset_again", 32'(timeout_err), 32'd1);
    endtask

    task automatic t_reset_mid();
        step();
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_address = 32'h61;
        smp();
        chk("t6_ready_rd", 32'(cmd_ready), 32'd1);
        step();
        cmd_write      = 1'b1;
        cmd_address    = 32'h70;
        cmd_wdata      = 8'h3C;
        cmd_byteenable = 4'hF;
        smp();
        chk("t6_ready_wr", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid   = 1'b0;
        waitrequest = 1'b1;
        smp();
        chk("t6_pending2", 32'(pending_count), 32'd2);
        chk("t6_write_on", 32'(write_n), 32'd0);
        step();
        smp();
        chk("t6_write_stall", 32'(write_n), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_reset("t6_rst");
        step();
        reset       = 1'b0;
        waitrequest = 1'b0;
        smp();
        chk("t6_pending_rel", 32'(pending_count), 32'd0);
        inj_req++;
        step();
        smp();
        chk("t6_late_rdv", 32'(readdatavalid), 32'd1);
        chk("t6_pending_late", 32'(pending_count), 32'd0);
        step();
        smp();
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
        chk("t6_pending_hold", 32'(pending_count), 32'd0);
        rsp_en = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        cmd_valid      = 1'b1;
        cmd_write      = 1'b1;
        cmd_address    = 32'h0;
        cmd_wdata      = 8'h0;
        cmd_byteenable = 4'h0;
        err_clear      = 1'b0;
        waitrequest    = 1'b0;
        readdatavalid  = 1'b0;
        readData       = 8'h00;
        fork
            responder();
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: run did not end");
                $fatal(1);
            end
        join_none
        smp();
        smp();
        chk_reset("rst");
        step();
        reset     = 1'b0;
        cmd_valid = 1'b0;
        smp();
        t_write();
        t_stall();
        t_pipe();
        t_incdec();
        t_timeout();
        t_reset_mid();
        step();
        smp();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
